// File: rtl/vad_frame_fsm.sv
// Frame-energy voice activity detector: saturating per-frame power accumulator
// feeding an attack/hangover FSM with ON/OFF hysteresis. Optional VAD_NOISE_ADAPT_EN
// adds a tracked noise floor that offsets both thresholds.
module vad_frame_fsm #(
    parameter int DATA_W        = 50,
    parameter int ACC_W         = 59,
    parameter int SHIFT         = 16,
    parameter int THRESH_ON     = 12,
    parameter int THRESH_OFF    = 8,
    parameter int ATTACK_FRAMES = 2,
    parameter int HANG_FRAMES   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dv,
    input  logic signed [DATA_W-1:0] data,
    input  logic                     ready,
    output logic [ACC_W-SHIFT-1:0]   frame_pwr,
    output logic                     result,
    output logic                     result_valid
`ifdef VAD_NOISE_ADAPT_EN
    ,
    output logic [ACC_W-SHIFT-1:0]   noise_floor
`endif
);

    localparam int PW     = ACC_W - SHIFT;
    localparam int MAXF   = (ATTACK_FRAMES > HANG_FRAMES) ? ATTACK_FRAMES : HANG_FRAMES;
    localparam int CNT_W  = $clog2(MAXF + 1);
    localparam int CW1    = CNT_W + 1;
    localparam logic [CNT_W:0] ATT_L  = CW1'(ATTACK_FRAMES);
    localparam logic [CNT_W:0] HANG_L = CW1'(HANG_FRAMES);
    localparam logic [PW-1:0]  ON_L   = PW'(THRESH_ON);
    localparam logic [PW-1:0]  OFF_L  = PW'(THRESH_OFF);

    typedef enum logic [1:0] {SILENCE, ATTACK, SPEECH, HANG} state_t;

    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                         input logic signed [DATA_W-1:0] d);
        logic signed [ACC_W:0] s;
        s = (ACC_W+1)'(a) + (ACC_W+1)'(d);
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

    // Negative frame sums clamp to zero power before scaling.
    function automatic logic [PW-1:0] scale_pwr(input logic signed [ACC_W-1:0] a);
        if (a[ACC_W-1])
            return '0;
        return PW'(a >>> SHIFT);
    endfunction

`ifdef VAD_NOISE_ADAPT_EN
    function automatic logic [PW-1:0] thr_add(input logic [PW-1:0] nf, input logic [PW-1:0] t);
        logic [PW:0] s;
        s = {1'b0, nf} + {1'b0, t};
        return s[PW] ? '1 : s[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] nf_track(input logic [PW-1:0] nf, input logic [PW-1:0] p);
        logic signed [PW+1:0] diff;
        logic signed [PW+1:0] nxt;
        diff = $signed({2'b00, p}) - $signed({2'b00, nf});
        nxt  = $signed({2'b00, nf}) + (diff >>> 3);
        if (nxt[PW+1])
            return '0;
        if (nxt[PW])
            return '1;
        return nxt[PW-1:0];
    endfunction
`endif

    logic                    dv_q, ready_q;
    logic                    dv_edge, rdy_edge;
    logic signed [ACC_W-1:0] acc_p0;
    logic                    vld_p1;
    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [CNT_W:0]          cnt_inc;
    logic                    result_nxt;
    logic [PW-1:0]           on_thr, off_thr;
    logic                    is_on, is_off;

    assign dv_edge  = dv & ~dv_q;
    assign rdy_edge = ready & ~ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dv_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            dv_q    <= dv;
            ready_q <= ready;
        end
    end

    // Stage p0 -> p1: accumulate samples, close frame on ready edge
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_p0    <= '0;
            frame_pwr <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= rdy_edge;
            if (rdy_edge) begin
                frame_pwr <= scale_pwr(acc_p0);
                acc_p0    <= dv_edge ? ACC_W'(data) : '0;
            end else if (dv_edge) begin
                acc_p0 <= sat_add(acc_p0, data);
            end
        end
    end

`ifdef VAD_NOISE_ADAPT_EN
    logic [PW-1:0] nf;
    assign noise_floor = nf;
    assign on_thr      = thr_add(nf, ON_L);
    assign off_thr     = thr_add(nf, OFF_L);

    always_ff @(posedge clk) begin
        if (reset)
            nf <= '0;
        else if (vld_p1 && state == SILENCE)
            nf <= nf_track(nf, frame_pwr);
    end
`else
    assign on_thr  = ON_L;
    assign off_thr = OFF_L;
`endif

    assign is_on   = frame_pwr > on_thr;
    assign is_off  = frame_pwr <= off_thr;
    assign cnt_inc = {1'b0, cnt} + CW1'(1);

    // Stage p1 -> p2: decision state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SILENCE;
            cnt          <= '0;
            result       <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            result       <= result_nxt;
            result_valid <= vld_p1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (vld_p1) begin
            case (state)
                SILENCE: begin
                    if (is_on) begin
                        if (ATTACK_FRAMES == 1) begin
                            state_nxt = SPEECH;
                        end else begin
                            state_nxt = ATTACK;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                ATTACK: begin
                    if (is_on) begin
                        if (cnt_inc == ATT_L) begin
                            state_nxt = SPEECH;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt_inc[CNT_W-1:0];
                        end
                    end else begin
                        state_nxt = SILENCE;
                        cnt_nxt   = '0;
                    end
                end
                SPEECH: begin
                    if (is_off) begin
                        state_nxt = (HANG_FRAMES > 0) ? HANG : SILENCE;
                        cnt_nxt   = '0;
                    end
                end
                HANG: begin
                    if (is_on) begin
                        state_nxt = SPEECH;
                        cnt_nxt   = '0;
                    end else if (cnt_inc == HANG_L) begin
                        state_nxt = SILENCE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc[CNT_W-1:0];
                    end
                end
                default: begin
                    state_nxt = SILENCE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        result_nxt = (state_nxt == SPEECH) || (state_nxt == HANG);
    end

endmodule

// File: tb/tb_vad_frame_fsm.sv
// Directed bench for vad_frame_fsm: default instance for FSM behaviour plus a
// narrow ACC_W=24/SHIFT=4 instance for accumulator saturation.
module tb_vad_frame_fsm;

    logic               clk = 1'b0;
    logic               reset;
    logic               dv, ready;
    logic signed [49:0] data;
    logic [42:0]        frame_pwr;
    logic               result, result_valid;

    logic               dv_s, ready_s;
    logic signed [23:0] data_s;
    logic [19:0]        frame_pwr_s;
    logic               result_s, result_valid_s;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vad_frame_fsm dut (
        .clk(clk), .reset(reset), .dv(dv), .data(data), .ready(ready),
        .frame_pwr(frame_pwr), .result(result), .result_valid(result_valid)
    );

    vad_frame_fsm #(.DATA_W(24), .ACC_W(24), .SHIFT(4)) dut_s (
        .clk(clk), .reset(reset), .dv(dv_s), .data(data_s), .ready(ready_s),
        .frame_pwr(frame_pwr_s), .result(result_s), .result_valid(result_valid_s)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic send_sample(input logic signed [49:0] d);
        @(negedge clk);
        data = d;
        dv   = 1'b1;
        @(negedge clk);
        dv   = 1'b0;
    endtask

    task automatic close_frame(input string tag, input logic [63:0] exp_pwr, input logic exp_res,
                               input logic with_dv, input logic signed [49:0] d);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        ready = 1'b1;
        if (with_dv) begin
            dv   = 1'b1;
            data = d;
        end
        @(negedge clk);
        ready = 1'b0;
        dv    = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (result_valid) seen = 1'b1;
        end
        chk({tag, "_rv"}, 64'(seen), 64'd1);
        chk({tag, "_pwr"}, 64'(frame_pwr), exp_pwr);
        chk({tag, "_res"}, 64'(result), 64'(exp_res));
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(result_valid), 64'd0);
    endtask

    initial begin
        bit seen_s;
        reset = 1'b1; dv = 1'b0; ready = 1'b0; data = '0;
        dv_s = 1'b0; ready_s = 1'b0; data_s = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_pwr", 64'(frame_pwr), 64'd0);
        chk("rst_res", 64'(result), 64'd0);
        chk("rst_rv", 64'(result_valid), 64'd0);

        // attack: two frames of pwr 16
        repeat (4) send_sample(50'sd262144);
        close_frame("att1", 64'd16, 1'b0, 1'b0, '0);
        repeat (4) send_sample(50'sd262144);
        close_frame("att2", 64'd16, 1'b1, 1'b0, '0);

        // hysteresis: 10 holds SPEECH, 8 enters HANG
        send_sample(50'sd655360);
        close_frame("hys10", 64'd10, 1'b1, 1'b0, '0);
        send_sample(50'sd524288);
        close_frame("hys8", 64'd8, 1'b1, 1'b0, '0);
        // loud frame in HANG returns to SPEECH
        send_sample(50'sd1048576);
        close_frame("hang_ret", 64'd16, 1'b1, 1'b0, '0);

        // hangover: three low frames held, fourth drops
        send_sample(50'sd0);
        close_frame("hang1", 64'd0, 1'b1, 1'b0, '0);
        close_frame("hang2", 64'd0, 1'b1, 1'b0, '0);
        close_frame("hang3", 64'd0, 1'b1, 1'b0, '0);
        close_frame("hang4", 64'd0, 1'b0, 1'b0, '0);

        // simultaneous dv and ready edges
        send_sample(50'sd65536);
        close_frame("simul1", 64'd1, 1'b0, 1'b1, 50'sd1310720);
        close_frame("simul2", 64'd20, 1'b0, 1'b0, '0);

        // negative frame clamps to zero power, ATTACK falls back
        send_sample(-50'sd655360);
        close_frame("neg", 64'd0, 1'b0, 1'b0, '0);

        // reset mid-frame
        repeat (2) send_sample(50'sd262144);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rv_a", 64'(result_valid), 64'd0);
        @(negedge clk);
        chk("mid_rv_b", 64'(result_valid), 64'd0);
        close_frame("mid_close", 64'd0, 1'b0, 1'b0, '0);
        repeat (4) send_sample(50'sd262144);
        close_frame("mid_att", 64'd16, 1'b0, 1'b0, '0);

        // saturation on the narrow instance
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data_s = 24'sd4194304;
            dv_s   = 1'b1;
            @(negedge clk);
            dv_s   = 1'b0;
        end
        @(negedge clk);
        ready_s = 1'b1;
        @(negedge clk);
        ready_s = 1'b0;
        seen_s  = 1'b0;
        for (int k = 0; k < 8 && !seen_s; k++) begin
            @(negedge clk);
            if (result_valid_s) seen_s = 1'b1;
        end
        chk("sat_rv", 64'(seen_s), 64'd1);
        chk("sat_pwr", 64'(frame_pwr_s), 64'd524287);
        chk("sat_res", 64'(result_s), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
